cpu_axi_bridge: RTL and testbench
=================================

# cpu_axi_bridge

Converts the CPU core's instruction and data request ports into one AXI-style master, directly downstream of the five-stage datapath. Requests use a req/addr_ok/data_ok handshake. The bridge serialises reads from both masters and runs data writes concurrently with instruction reads. It is the block between the core and the system interconnect.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- inst_req / inst_wr  in  1 / 1  fetch request / write flag (always 0; ignored)
- inst_size / inst_addr  in  2 / 32  0=byte, 1=half, 2=word / byte address
- inst_wdata  in  32  unused
- inst_addr_ok / inst_data_ok  out  1 / 1  request accepted / read data valid
- inst_rdata  out  32  fetched word
- data_req / data_wr  in  1 / 1  data request / 1=store
- data_size / data_addr  in  2 / 32  as inst
- data_wdata  in  32  store data, already lane-aligned by the core
- data_addr_ok / data_data_ok  out  1 / 1  accepted / completed (load data or store ack)
- data_rdata  out  32  load word
- arid / araddr / arsize  out  4 / 32 / 3  read address channel
- arvalid / arready  out / in  1 / 1
- rid / rdata / rresp  in  4 / 32 / 2  read data channel
- rlast / rvalid  in  1 / 1
- rready  out  1
- awid / awaddr / awsize  out  4 / 32 / 3  write address channel
- awvalid / awready  out / in  1 / 1
- wid / wdata / wstrb  out  4 / 32 / 4  write data channel
- wlast / wvalid  out  1 / 1
- wready  in  1
- bid / bresp / bvalid  in  4 / 2 / 1  write response
- bready  out  1

The top wrapper ties len, burst, lock, cache and prot.

## Operation
- IDs: instruction read uses 0, data read uses 1, write uses 1. awid, wid and arid come from the accepted request. wlast is constant 1.
- Read FSM: R_IDLE, R_ADDR (arvalid=1), R_DATA (rready=1), with one read outstanding in total.
  - R_IDLE to R_ADDR on acceptance.
  - R_ADDR to R_DATA on arready.
  - R_DATA to R_IDLE on rvalid.
- Write FSM: W_IDLE, W_ADDR, W_RESP.
  - W_ADDR: awvalid and wvalid are both raised and each drops independently after its own handshake.
  - W_ADDR to W_RESP when both handshakes are done, in either order or the same cycle.
  - W_RESP: bready=1. W_RESP to W_IDLE on bvalid.
- Acceptance is combinational, within the request cycle:
  - data_addr_ok = data_req, no data transaction outstanding, and the relevant FSM idle (write FSM if data_wr, else read FSM).
  - inst_addr_ok = inst_req, read FSM in R_IDLE, and no data read accepted in the same cycle. Data reads win arbitration.
  - A data write and an instruction read may be accepted in the same cycle.
- Data port allows at most one outstanding transaction (read or write). This keeps completions in order and avoids read-after-write hazards.
- arsize/awsize = {0, size}.
- wstrb is derived from size and addr[1:0]:
  - byte: 1 shifted left by addr[1:0]
  - half: addr[1] ? 1100 : 0011
  - word: 1111
- Alignment is not checked; the core raises address exceptions before issuing.
- rresp and bresp are ignored.

## Timing
- Addresses, sizes and wdata are registered on acceptance. AXI valids rise the cycle after acceptance.
- On the rvalid & rready edge, rdata is captured and routed by rid. The matching data_ok pulses for exactly one cycle in the next cycle, with rdata valid in that same cycle.
- Store completion: data_data_ok pulses the cycle after bvalid & bready.
- Outstanding status clears on the completing handshake edge, so a new request can be accepted in the data_ok cycle.
- Minimum read latency is 3 cycles from the request cycle to data_ok, with arready and rvalid immediate. Minimum write latency is also 3 cycles.
- Valids hold stable until handshake, regardless of ready.
- Reset asserted at any time, including mid-transaction:
  - All outputs go to 0 immediately: valids, readys, addr_ok, data_ok, rdata, and the AXI address/data/strb/id fields.
  - FSMs return to idle and in-flight transactions are abandoned.

## Structure
- Shared package `bridge_pkg`:
  - ID constants INST_ID=0, DATA_ID=1
  - read and write state enums
  - `size2strb(size, addr_lo)` function
- Single module; no sub-module is needed. The read and write FSMs are separate always blocks.

## Test plan
- **Instruction read:** inst_req addr 0xBFC00000 in cycle 0, arready immediate, rvalid cycle 2 with rdata 0x3C010001 rid 0 → inst_addr_ok cycle 0, arvalid cycle 1, inst_data_ok with inst_rdata 0x3C010001 in cycle 3.
- **Read arbitration:** inst_req and data read at 0x80001000 in the same cycle → data_addr_ok=1, inst_addr_ok=0. araddr 0x80001000 with arid 1 is issued first. Instruction read is accepted in the data_data_ok cycle.
- **Store strobes:**
  - sb at 0x80000003 → wstrb 1000, awsize 0.
  - sh at 0x80000002 → wstrb 1100, awsize 1.
  - sw → wstrb 1111, awsize 2.
- **Concurrent write and fetch:** store with awready delayed 3 cycles and wready immediate, plus a concurrent instruction read → wvalid drops after 1 cycle, awvalid holds 3 cycles. Fetch completes independently. data_data_ok comes 1 cycle after bvalid.
- **Data back-pressure:** data load requested while a data store is outstanding → data_addr_ok stays 0 until the store's data_ok cycle, then is accepted.
- **Reset mid-read:** rst_n dropped while arvalid=1 and in R_DATA → arvalid, rready and data_ok are 0 immediately. After release, the FSM is idle and the first request is accepted normally.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared types and helpers for the CPU-to-AXI bridge: transaction IDs,
// read/write FSM state encodings and the store byte-strobe decoder.
package bridge_pkg;

  localparam logic [3:0] INST_ID = 4'd0;
  localparam logic [3:0] DATA_ID = 4'd1;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_t;

  function automatic logic [3:0] size2strb(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      2'd0:    strb = 4'b0001 << addr_lo;
      2'd1:    strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/cpu_axi_bridge.sv
// Bridges the core's instruction/data req/addr_ok/data_ok ports onto one AXI-style
// master: one read outstanding in total, data writes run alongside instruction reads.
module cpu_axi_bridge
  import bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arsize,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [3:0]        awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [2:0]        awsize,
  output logic              awvalid,
  input  logic              awready,
  output logic [3:0]        wid,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [3:0]        bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  r_state_t r_state, r_next;
  w_state_t w_state, w_next;
  logic     data_busy, aw_done, w_done;
  logic     data_rd_acc, data_wr_acc, inst_acc, rd_acc;
  logic     rd_done, wr_done, aw_hs, w_hs;
  logic     unused_ok;

  assign unused_ok = ^{inst_wr, inst_wdata, rresp, rlast, bid, bresp};

  // Acceptance is combinational; data reads win the shared read channel.
  assign data_rd_acc  = rst_n & data_req & ~data_wr & ~data_busy & (r_state == R_IDLE);
  assign data_wr_acc  = rst_n & data_req &  data_wr & ~data_busy & (w_state == W_IDLE);
  assign inst_acc     = rst_n & inst_req & (r_state == R_IDLE) & ~data_rd_acc;
  assign rd_acc       = data_rd_acc | inst_acc;
  assign data_addr_ok = data_rd_acc | data_wr_acc;
  assign inst_addr_ok = inst_acc;

  assign rd_done = (r_state == R_DATA) & rvalid;
  assign wr_done = (w_state == W_RESP) & bvalid;
  assign wid     = awid;
  assign wlast   = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next  = r_state;
    arvalid = 1'b0;
    rready  = 1'b0;
    case (r_state)
      R_IDLE: if (rd_acc) r_next = R_ADDR;
      R_ADDR: begin
        arvalid = 1'b1;
        if (arready) r_next = R_DATA;
      end
      R_DATA: begin
        rready = 1'b1;
        if (rvalid) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  always_comb begin
    w_next  = w_state;
    awvalid = (w_state == W_ADDR) & ~aw_done;
    wvalid  = (w_state == W_ADDR) & ~w_done;
    bready  = (w_state == W_RESP);
    aw_hs   = awvalid & awready;
    w_hs    = wvalid & wready;
    case (w_state)
      W_IDLE: if (data_wr_acc) w_next = W_ADDR;
      W_ADDR: if ((aw_done | aw_hs) & (w_done | w_hs)) w_next = W_RESP;
      W_RESP: if (bvalid) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Request capture on acceptance drives the AXI address/data fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arid   <= '0;
      araddr <= '0;
      arsize <= '0;
    end else if (data_rd_acc) begin
      arid   <= DATA_ID;
      araddr <= data_addr;
      arsize <= {1'b0, data_size};
    end else if (inst_acc) begin
      arid   <= INST_ID;
      araddr <= inst_addr;
      arsize <= {1'b0, inst_size};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awid   <= '0;
      awaddr <= '0;
      awsize <= '0;
      wdata  <= '0;
      wstrb  <= '0;
    end else if (data_wr_acc) begin
      awid   <= DATA_ID;
      awaddr <= data_addr;
      awsize <= {1'b0, data_size};
      wdata  <= data_wdata;
      wstrb  <= size2strb(data_size, data_addr[1:0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (data_wr_acc) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

  // Completion: data_ok pulses the cycle after the closing handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_busy    <= 1'b0;
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      inst_rdata   <= '0;
      data_rdata   <= '0;
    end else begin
      inst_data_ok <= rd_done & (rid == INST_ID);
      data_data_ok <= (rd_done & (rid == DATA_ID)) | wr_done;
      if (rd_done && rid == INST_ID) inst_rdata <= rdata;
      if (rd_done && rid == DATA_ID) data_rdata <= rdata;
      if (data_addr_ok)
        data_busy <= 1'b1;
      else if ((rd_done && rid == DATA_ID) || wr_done)
        data_busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge: tasks drive core requests and AXI responses;
// read data is checked through per-port scoreboard queues popped on data_ok.
module tb_cpu_axi_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid, awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  int checks = 0;
  int errors = 0;

  // Entries: {is_load, expected rdata}
  logic [32:0] inst_q[$];
  logic [32:0] data_q[$];
  logic [32:0] inst_e, data_e;

  cpu_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every data_ok must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (inst_data_ok) begin
        checks++;
        if (inst_q.size() == 0) begin
          errors++;
          $display("FAIL inst_sb: unexpected inst_data_ok, rdata=%h", inst_rdata);
        end else begin
          inst_e = inst_q.pop_front();
          if (inst_rdata !== inst_e[31:0]) begin
            errors++;
            $display("FAIL inst_sb: inst_rdata=%h expected %h", inst_rdata, inst_e[31:0]);
          end
        end
      end
      if (data_data_ok) begin
        checks++;
        if (data_q.size() == 0) begin
          errors++;
          $display("FAIL data_sb: unexpected data_data_ok, rdata=%h", data_rdata);
        end else begin
          data_e = data_q.pop_front();
          if (data_e[32] && data_rdata !== data_e[31:0]) begin
            errors++;
            $display("FAIL data_sb: data_rdata=%h expected %h", data_rdata, data_e[31:0]);
          end
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Waits for arvalid, accepts it, then returns read data; ends in the data_ok cycle.
  task automatic serve_read(input logic [31:0] rd, input logic [3:0] id);
    int n = 0;
    while (arvalid !== 1'b1 && n < 10) begin step(); n++; end
    if (arvalid !== 1'b1) begin
      checks++; errors++;
      $display("FAIL serve_read: arvalid=%b never rose, expected 1", arvalid);
    end
    arready = 1'b1; step(); arready = 1'b0;
    n = 0;
    while (rready !== 1'b1 && n < 10) begin step(); n++; end
    if (rready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL serve_read: rready=%b never rose, expected 1", rready);
    end
    rvalid = 1'b1; rdata = rd; rid = id; step();
    rvalid = 1'b0; rdata = '0; rid = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b0;
    #3;
    checks++;
    if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ok: addr_ok/data_ok=%b expected 0000",
               {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
    end
    checks++;
    if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_hs: ar/r/aw/w/b=%b expected 00000",
               {arvalid, rready, awvalid, wvalid, bready});
    end
    checks++;
    if ({araddr, awaddr, wdata, wstrb, arid, awid, inst_rdata, data_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_fields: araddr=%h awaddr=%h wdata=%h wstrb=%b expected all 0",
               araddr, awaddr, wdata, wstrb);
    end
    inst_req = 1'b0; data_req = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_inst_read;
    step();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000; inst_size = 2'd2;
    #1;
    checks++;
    if (inst_addr_ok !== 1'b1) begin
      errors++; $display("FAIL inst_accept: inst_addr_ok=%b expected 1", inst_addr_ok);
    end
    inst_q.push_back({1'b1, 32'h3C01_0001});
    step();
    inst_req = 1'b0;
    checks++;
    if ({arvalid, araddr, arid, arsize} !== {1'b1, 32'hBFC0_0000, 4'd0, 3'd2}) begin
      errors++;
      $display("FAIL inst_ar: arvalid=%b araddr=%h arid=%0d arsize=%0d expected 1 bfc00000 0 2",
               arvalid, araddr, arid, arsize);
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    checks++;
    if ({arvalid, rready} !== 2'b01) begin
      errors++; $display("FAIL inst_r: arvalid/rready=%b expected 01", {arvalid, rready});
    end
    rvalid = 1'b1; rdata = 32'h3C01_0001; rid = 4'd0;
    step();
    rvalid = 1'b0; rdata = '0;
    checks++;
    if (inst_data_ok !== 1'b1) begin
      errors++; $display("FAIL inst_latency: inst_data_ok=%b in cycle 3, expected 1", inst_data_ok);
    end
    step();
    checks++;
    if (inst_data_ok !== 1'b0) begin
      errors++; $display("FAIL inst_pulse: inst_data_ok=%b in cycle 4, expected 0", inst_data_ok);
    end
  endtask

  task automatic test_read_arb;
    step();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0004; inst_size = 2'd2;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_1000; data_size = 2'd2;
    #1;
    checks++;
    if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin
      errors++;
      $display("FAIL arb_accept: data_addr_ok/inst_addr_ok=%b expected 10", {data_addr_ok, inst_addr_ok});
    end
    data_q.push_back({1'b1, 32'h1111_2222});
    step();
    data_req = 1'b0;
    #1;
    checks++;
    if ({arvalid, araddr, arid, inst_addr_ok} !== {1'b1, 32'h8000_1000, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL arb_order: arvalid=%b araddr=%h arid=%0d inst_addr_ok=%b expected 1 80001000 1 0",
               arvalid, araddr, arid, inst_addr_ok);
    end
    serve_read(32'h1111_2222, 4'd1);
    #1;
    checks++;
    if ({data_data_ok, inst_addr_ok} !== 2'b11) begin
      errors++;
      $display("FAIL arb_followup: data_data_ok/inst_addr_ok=%b expected 11", {data_data_ok, inst_addr_ok});
    end
    inst_q.push_back({1'b1, 32'h2402_0005});
    step();
    inst_req = 1'b0;
    checks++;
    if ({araddr, arid} !== {32'hBFC0_0004, 4'd0}) begin
      errors++;
      $display("FAIL arb_inst_ar: araddr=%h arid=%0d expected bfc00004 0", araddr, arid);
    end
    serve_read(32'h2402_0005, 4'd0);
    step();
  endtask

  task automatic test_store_strobes;
    logic [31:0] addrs [3] = '{32'h8000_0003, 32'h8000_0002, 32'h8000_0008};
    logic [1:0]  sizes [3] = '{2'd0, 2'd1, 2'd2};
    logic [31:0] wds   [3] = '{32'hAB00_0000, 32'hCDEF_0000, 32'h1234_5678};
    logic [3:0]  strbs [3] = '{4'b1000, 4'b1100, 4'b1111};
    for (int i = 0; i < 3; i++) begin
      step();
      data_req = 1'b1; data_wr = 1'b1; data_addr = addrs[i]; data_size = sizes[i]; data_wdata = wds[i];
      #1;
      checks++;
      if (data_addr_ok !== 1'b1) begin
        errors++; $display("FAIL store_accept[%0d]: data_addr_ok=%b expected 1", i, data_addr_ok);
      end
      data_q.push_back({1'b0, 32'h0});
      step();
      data_req = 1'b0; data_wr = 1'b0;
      checks++;
      if ({awvalid, wvalid, awaddr, awsize, wdata, wstrb, awid, wid, wlast} !==
          {1'b1, 1'b1, addrs[i], {1'b0, sizes[i]}, wds[i], strbs[i], 4'd1, 4'd1, 1'b1}) begin
        errors++;
        $display("FAIL store_aw[%0d]: awv=%b wv=%b awaddr=%h awsize=%0d wdata=%h wstrb=%b awid=%0d wid=%0d expected 1 1 %h %0d %h %b 1 1",
                 i, awvalid, wvalid, awaddr, awsize, wdata, wstrb, awid, wid,
                 addrs[i], sizes[i], wds[i], strbs[i]);
      end
      awready = 1'b1; wready = 1'b1;
      step();
      awready = 1'b0; wready = 1'b0;
      checks++;
      if ({awvalid, wvalid, bready} !== 3'b001) begin
        errors++;
        $display("FAIL store_resp[%0d]: awv/wv/bready=%b expected 001", i, {awvalid, wvalid, bready});
      end
      bvalid = 1'b1;
      step();
      bvalid = 1'b0;
      checks++;
      if (data_data_ok !== 1'b1) begin
        errors++; $display("FAIL store_done[%0d]: data_data_ok=%b expected 1", i, data_data_ok);
      end
    end
    step();
  endtask

  task automatic test_concurrent;
    step();
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h8000_0010; data_size = 2'd2; data_wdata = 32'hCAFE_F00D;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0008; inst_size = 2'd2;
    #1;
    checks++;
    if ({data_addr_ok, inst_addr_ok} !== 2'b11) begin
      errors++;
      $display("FAIL conc_accept: data_addr_ok/inst_addr_ok=%b expected 11", {data_addr_ok, inst_addr_ok});
    end
    data_q.push_back({1'b0, 32'h0});
    inst_q.push_back({1'b1, 32'h8C21_0004});
    step();
    data_req = 1'b0; data_wr = 1'b0; inst_req = 1'b0;
    checks++;
    if ({awvalid, wvalid, arvalid} !== 3'b111) begin
      errors++; $display("FAIL conc_valids: aw/w/ar=%b expected 111", {awvalid, wvalid, arvalid});
    end
    wready = 1'b1; arready = 1'b1;
    step();
    wready = 1'b0; arready = 1'b0;
    checks++;
    if ({awvalid, wvalid} !== 2'b10) begin
      errors++; $display("FAIL conc_wdrop: aw/w=%b in cycle 2, expected 10", {awvalid, wvalid});
    end
    rvalid = 1'b1; rdata = 32'h8C21_0004; rid = 4'd0;
    step();
    rvalid = 1'b0; rdata = '0;
    checks++;
    if ({awvalid, wvalid, inst_data_ok} !== 3'b101) begin
      errors++;
      $display("FAIL conc_hold: aw/w/inst_data_ok=%b in cycle 3, expected 101", {awvalid, wvalid, inst_data_ok});
    end
    awready = 1'b1;
    step();
    awready = 1'b0;
    checks++;
    if ({awvalid, bready} !== 2'b01) begin
      errors++; $display("FAIL conc_awdone: awvalid/bready=%b expected 01", {awvalid, bready});
    end
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    checks++;
    if (data_data_ok !== 1'b1) begin
      errors++; $display("FAIL conc_bdone: data_data_ok=%b expected 1", data_data_ok);
    end
    step();
  endtask

  task automatic test_back_pressure;
    step();
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h8000_0020; data_size = 2'd2; data_wdata = 32'h0BAD_BEEF;
    #1;
    data_q.push_back({1'b0, 32'h0});
    step();
    data_wr = 1'b0; data_addr = 32'h8000_2000;
    #1;
    checks++;
    if (data_addr_ok !== 1'b0) begin
      errors++; $display("FAIL bp_block1: data_addr_ok=%b with store outstanding, expected 0", data_addr_ok);
    end
    awready = 1'b1; wready = 1'b1;
    step();
    awready = 1'b0; wready = 1'b0;
    #1;
    checks++;
    if (data_addr_ok !== 1'b0) begin
      errors++; $display("FAIL bp_block2: data_addr_ok=%b with store outstanding, expected 0", data_addr_ok);
    end
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    #1;
    checks++;
    if ({data_data_ok, data_addr_ok} !== 2'b11) begin
      errors++;
      $display("FAIL bp_release: data_data_ok/data_addr_ok=%b expected 11", {data_data_ok, data_addr_ok});
    end
    data_q.push_back({1'b1, 32'h5A5A_0F0F});
    step();
    data_req = 1'b0;
    serve_read(32'h5A5A_0F0F, 4'd1);
    checks++;
    if (data_data_ok !== 1'b1) begin
      errors++; $display("FAIL bp_load: data_data_ok=%b expected 1", data_data_ok);
    end
    step();
  endtask

  task automatic test_reset_mid;
    step();
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_3000; data_size = 2'd2;
    step();
    data_req = 1'b0;
    checks++;
    if (arvalid !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre: arvalid=%b expected 1", arvalid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({arvalid, rready, data_data_ok, araddr, arid} !== '0) begin
      errors++;
      $display("FAIL rst_in_addr: arvalid=%b rready=%b data_ok=%b araddr=%h expected all 0",
               arvalid, rready, data_data_ok, araddr);
    end
    step(); step();
    rst_n = 1'b1;
    step();
    data_req = 1'b1; data_addr = 32'h8000_3004;
    #1;
    checks++;
    if (data_addr_ok !== 1'b1) begin
      errors++; $display("FAIL rst_reaccept: data_addr_ok=%b expected 1", data_addr_ok);
    end
    step();
    data_req = 1'b0; arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rid = 4'd1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({arvalid, rready, data_data_ok, inst_data_ok} !== 4'b0) begin
      errors++;
      $display("FAIL rst_in_data: ar/r/data_ok/inst_ok=%b expected 0000",
               {arvalid, rready, data_data_ok, inst_data_ok});
    end
    step();
    rvalid = 1'b0; rdata = '0; rid = '0;
    step();
    rst_n = 1'b1;
    step();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0100; inst_size = 2'd2;
    #1;
    checks++;
    if ({inst_addr_ok, arvalid} !== 2'b10) begin
      errors++;
      $display("FAIL rst_idle: inst_addr_ok/arvalid=%b after reset, expected 10", {inst_addr_ok, arvalid});
    end
    inst_q.push_back({1'b1, 32'h0000_0021});
    step();
    inst_req = 1'b0;
    serve_read(32'h0000_0021, 4'd0);
    checks++;
    if (inst_data_ok !== 1'b1) begin
      errors++; $display("FAIL rst_first_read: inst_data_ok=%b expected 1", inst_data_ok);
    end
    step(); step();
  endtask

  initial begin
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
    rst_n = 0;

    test_reset();
    test_inst_read();
    test_read_arb();
    test_store_strobes();
    test_concurrent();
    test_back_pressure();
    test_reset_mid();

    checks++;
    if (inst_q.size() != 0 || data_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d inst and %0d data expectations left, expected 0 and 0",
               inst_q.size(), data_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
